// File: rtl/shift_capture.sv
// Captures MSB-first serial frames from an external shift register and publishes
// each complete word through a valid/ready port with change mask and sticky error flags.
module shift_capture #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_shld,
    input  logic             i_serclk,
    input  logic             i_done,
    input  logic             i_sdata,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_changed,
    output logic             o_overrun,
    output logic             o_frame_err
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    bitcnt;
    logic             done_q;
    logic             done_rise;
    logic             publish_req;
    logic             publish_ok;

    assign done_rise   = i_done & ~done_q;
    assign publish_req = done_rise && (state == SHIFT) && (bitcnt == FULL);
    // A word may replace an unaccepted one only if it is being accepted this cycle.
    assign publish_ok  = ~o_valid | i_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= '0;
            prev        <= '0;
            bitcnt      <= '0;
            done_q      <= 1'b0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_changed   <= '0;
            o_overrun   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            done_q <= i_done;
            if (done_rise) begin
                if (!publish_req)
                    o_frame_err <= 1'b1;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!i_shld)
                            state <= LOAD;
                    end
                    LOAD: begin
                        acc    <= '0;
                        bitcnt <= '0;
                        if (i_shld)
                            state <= SHIFT;
                    end
                    SHIFT: begin
                        if (!i_shld) begin
                            state <= LOAD;
                        end else if (!i_serclk && !i_done) begin
                            if (bitcnt == FULL) begin
                                o_frame_err <= 1'b1;
                            end else begin
                                acc    <= {acc[WIDTH-2:0], i_sdata};
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (publish_req) begin
                if (publish_ok) begin
                    o_valid   <= 1'b1;
                    o_data    <= acc;
                    o_changed <= acc ^ prev;
                    prev      <= acc;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule
